// File: rtl/operand_dispatch_demux.sv
// Operand router: steers each operand word into a per-unit FIFO chosen by in_sel,
// with valid/ready handshakes on the input side and on every unit output.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module operand_dispatch_demux #(
  parameter int WORD_SIZE = `WORD_SIZE,
  parameter int NUM_UNITS = 3,
  parameter int SEL_WIDTH = 2,
  parameter int DEPTH     = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [SEL_WIDTH-1:0]                   in_sel,
  input  logic [WORD_SIZE-1:0]                   in_value,
  output logic [NUM_UNITS-1:0]                   out_valid,
  input  logic [NUM_UNITS-1:0]                   out_ready,
  output logic [NUM_UNITS*WORD_SIZE-1:0]         out_value,
  output logic [NUM_UNITS*($clog2(DEPTH)+1)-1:0] out_count,
  output logic                                   err_sel,
  input  logic                                   err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WORD_SIZE-1:0] mem_r    [NUM_UNITS][DEPTH];
  logic [PW-1:0]        wr_ptr_r [NUM_UNITS];
  logic [PW-1:0]        rd_ptr_r [NUM_UNITS];
  logic [CW-1:0]        count_r  [NUM_UNITS];
  logic [NUM_UNITS-1:0] push_s;
  logic [NUM_UNITS-1:0] pop_s;
  logic                 sel_ok_s;
  logic                 in_ready_s;
  logic                 err_sel_r;

  // Select decode, back-pressure and per-unit push/pop strobes
  always_comb begin
    sel_ok_s   = ({1'b0, in_sel} < (SEL_WIDTH+1)'(NUM_UNITS));
    in_ready_s = 1'b1;
    push_s     = {NUM_UNITS{1'b0}};
    pop_s      = {NUM_UNITS{1'b0}};
    for (int u = 0; u < NUM_UNITS; u++) begin
      // No full-pop pass-through: a full FIFO refuses even when its head leaves.
      in_ready_s = in_ready_s & ~((in_sel == SEL_WIDTH'(u)) & (count_r[u] == CW'(DEPTH)));
      push_s[u]  = in_valid & (in_sel == SEL_WIDTH'(u)) & (count_r[u] != CW'(DEPTH));
      pop_s[u]   = out_ready[u] & (count_r[u] != CW'(0));
    end
  end

  // Output view of the FIFO heads and occupancies
  always_comb begin
    out_valid = {NUM_UNITS{1'b0}};
    out_value = {(NUM_UNITS*WORD_SIZE){1'b0}};
    out_count = {(NUM_UNITS*CW){1'b0}};
    for (int u = 0; u < NUM_UNITS; u++) begin
      out_valid[u]                       = (count_r[u] != CW'(0));
      out_count[u*CW +: CW]              = count_r[u];
      out_value[u*WORD_SIZE +: WORD_SIZE] = (count_r[u] != CW'(0)) ? mem_r[u][rd_ptr_r[u]]
                                                                   : {WORD_SIZE{1'b0}};
    end
  end

  // Pointer and occupancy registers, flushed by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        wr_ptr_r[u] <= PW'(0);
        rd_ptr_r[u] <= PW'(0);
        count_r[u]  <= CW'(0);
      end
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (push_s[u]) wr_ptr_r[u] <= wr_ptr_r[u] + PW'(1);
        else           wr_ptr_r[u] <= wr_ptr_r[u];
        if (pop_s[u])  rd_ptr_r[u] <= rd_ptr_r[u] + PW'(1);
        else           rd_ptr_r[u] <= rd_ptr_r[u];
        case ({push_s[u], pop_s[u]})
          2'b10:   count_r[u] <= count_r[u] + CW'(1);
          2'b01:   count_r[u] <= count_r[u] - CW'(1);
          default: count_r[u] <= count_r[u];
        endcase
      end
    end
  end

  // Operand storage; contents are deliberately not reset
  always_ff @(posedge clk) begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (push_s[u]) mem_r[u][wr_ptr_r[u]] <= in_value;
    end
  end

  // Sticky invalid-select flag; a new error wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         err_sel_r <= 1'b0;
    else if (in_valid && !sel_ok_s)  err_sel_r <= 1'b1;
    else if (err_clr)                err_sel_r <= 1'b0;
    else                             err_sel_r <= err_sel_r;
  end

  assign in_ready = in_ready_s;
  assign err_sel  = err_sel_r;

endmodule

// File: tb/tb_operand_dispatch_demux.sv
// Scoreboard bench for operand_dispatch_demux: per-unit expected queues filled on
// accepted beats, drained by a monitor on every output handshake.
module tb_operand_dispatch_demux;

  localparam int W  = 8;
  localparam int NU = 3;
  localparam int SW = 2;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   in_sel;
  logic [W-1:0]    in_value;
  logic [NU-1:0]   out_valid;
  logic [NU-1:0]   out_ready;
  logic [NU*W-1:0] out_value;
  logic [NU*CW-1:0] out_count;
  logic            err_sel;
  logic            err_clr;

  operand_dispatch_demux #(.WORD_SIZE(W), .NUM_UNITS(NU), .SEL_WIDTH(SW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_value(in_value), .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_count(out_count), .err_sel(err_sel), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int       n_tests = 0;
  int       n_fail  = 0;
  logic [W-1:0] sb_q [NU][$];
  bit [NU-1:0]  popped = '0;
  bit           err_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs with the model and retire heads on each handshake
  always @(negedge clk) begin
    int sz;
    logic [W-1:0] exp_v;
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_count", 32'(out_count), 32'd0);
      chk("rst_out_value", 32'(out_value), 32'd0);
      chk("rst_err_sel", 32'(err_sel), 32'd0);
      for (int u = 0; u < NU; u++) sb_q[u].delete();
      popped = '0;
    end else begin
      for (int u = 0; u < NU; u++) begin
        sz    = sb_q[u].size();
        exp_v = (sz != 0) ? sb_q[u][0] : 8'h00;
        chk($sformatf("out_valid[%0d]", u), 32'(out_valid[u]), 32'(sz != 0));
        chk($sformatf("out_count[%0d]", u), 32'(out_count[u*CW +: CW]), 32'(sz));
        chk($sformatf("out_value[%0d]", u), 32'(out_value[u*W +: W]), 32'(exp_v));
        popped[u] = (sz != 0) && out_ready[u];
        if (popped[u]) void'(sb_q[u].pop_front());
      end
      chk("err_sel", 32'(err_sel), 32'(err_exp));
    end
  end

  // Feeder: predict acceptance of the offered beat and queue the expected word
  always @(negedge clk) begin
    bit exp_rdy;
    #1;
    if (rst) begin
      err_exp = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
    end else begin
      if (in_sel >= SW'(NU)) exp_rdy = 1'b1;
      else exp_rdy = (sb_q[in_sel].size() + int'(popped[in_sel])) < D;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (in_valid && in_sel >= SW'(NU)) err_exp = 1'b1;
      else if (err_clr) err_exp = 1'b0;
      if (in_valid && exp_rdy && in_sel < SW'(NU)) sb_q[in_sel].push_back(in_value);
    end
  end

  task automatic cyc(input bit v, input logic [SW-1:0] s, input logic [W-1:0] d,
                     input logic [NU-1:0] r, input bit c);
    in_valid = v; in_sel = s; in_value = d; out_ready = r; err_clr = c;
    @(posedge clk); #1;
  endtask

  task automatic push_wait(input logic [SW-1:0] s, input logic [W-1:0] d, input logic [NU-1:0] r);
    bit acc = 1'b0;
    in_valid = 1'b1; in_sel = s; in_value = d; out_ready = r; err_clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1'b1; break; end
    end
    chk("push_wait_timeout", 32'(acc), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 6; k++) cyc(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_value = '0; out_ready = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    cyc(1'b0, 2'd0, 8'h00, 3'b000, 1'b0);

    // route one word to each unit
    cyc(1'b1, 2'd0, 8'h11, 3'b000, 1'b0);
    cyc(1'b1, 2'd1, 8'h22, 3'b000, 1'b0);
    cyc(1'b1, 2'd2, 8'h33, 3'b000, 1'b0);
    in_valid = 1'b0;
    chk("route_valid", 32'(out_valid), 32'h7);
    chk("route_value", 32'(out_value), 32'h332211);
    chk("route_count", 32'(out_count), 32'(9'b001_001_001));
    drain();

    // fill unit 1 and hold the fifth word under back-pressure
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'd1, 8'hA0 + 8'(i), 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd1, 8'hA4, 3'b000, 1'b0);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(out_count[CW +: CW]), 32'd4);
    push_wait(2'd1, 8'hA4, 3'b010);
    drain();

    // steady push+pop on unit 0 at occupancy 2 (wraps pointers)
    cyc(1'b1, 2'd0, 8'h01, 3'b000, 1'b0);
    cyc(1'b1, 2'd0, 8'h02, 3'b000, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'd0, 8'($urandom), 3'b001, 1'b0);
    in_valid = 1'b0;
    chk("pushpop_count", 32'(out_count[0 +: CW]), 32'd2);
    drain();

    // invalid select, clear collision, plain clear
    cyc(1'b1, 2'd3, 8'hFF, 3'b000, 1'b0);
    chk("inv_err_set", 32'(err_sel), 32'd1);
    chk("inv_no_fifo", 32'(out_count), 32'd0);
    cyc(1'b1, 2'd3, 8'hEE, 3'b000, 1'b1);
    chk("inv_set_wins", 32'(err_sel), 32'd1);
    cyc(1'b0, 2'd0, 8'h00, 3'b000, 1'b1);
    chk("inv_clr", 32'(err_sel), 32'd0);

    // unit 2 full and stalled while 0/1 stream
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'd2, 8'hC0 + 8'(i), 3'b000, 1'b0);
    for (int i = 0; i < 60; i++)
      cyc(($urandom_range(0, 7) != 0), SW'($urandom_range(0, 2)), 8'($urandom), 3'b011, 1'b0);
    in_valid = 1'b0;
    chk("indep_u2_count", 32'(out_count[2*CW +: CW]), 32'd4);
    drain();

    // reset mid-stream with every unit at 3
    for (int i = 0; i < 9; i++) cyc(1'b1, SW'(i % 3), 8'($urandom), 3'b000, 1'b0);
    in_valid = 1'b1; in_sel = 2'd0; in_value = 8'h77; rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_count", 32'(out_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1'b1, 2'd0, 8'h5A, 3'b000, 1'b0);
    in_valid = 1'b0;
    chk("post_rst_count", 32'(out_count), 32'd1);
    chk("post_rst_value", 32'(out_value[0 +: W]), 32'h5A);
    drain();

    // random traffic including invalid selects and clears
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 3) != 0), SW'($urandom_range(0, 3)), 8'($urandom),
          NU'($urandom), ($urandom_range(0, 15) == 0));
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
